// File: rtl/dmem_bank_ctrl.sv
// Multi-bank data-memory controller for the MEM stage: bank decode, byte-lane steering, load extension, fault checks.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being silently aligned.
module dmem_bank_ctrl #(
    parameter int NUM_BANKS = 2,
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = 14
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              stall,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        dbg_state
);
    // Handshake: a request transfers on a posedge with req_valid & req_ready; a response
    // transfers on a posedge with rsp_valid & rsp_ready & !stall. Once rsp_valid rises,
    // rsp_rdata and rsp_err hold until that transfer.
    localparam int          DW    = $clog2(DEPTH);
    localparam int          BW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned LIMIT = NUM_BANKS * DEPTH * 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          funct3_q;
    logic                we_q;
    logic [31:0]         wdata_q;
    logic                load_ok_q;

    logic [DW-1:0]       word_idx;
    logic [BW-1:0]       bank_idx;
    logic                out_of_range;
    logic                illegal;
    logic                misalign;
    logic                fault;
    logic                acc_go;
    logic [3:0]          wstrb;
    logic [31:0]         wlanes;
    logic [NUM_BANKS-1:0]        bank_en;
    logic [NUM_BANKS-1:0][31:0]  bank_rd;

    assign word_idx     = addr_q[2 +: DW];
    assign bank_idx     = BW'(addr_q >> (2 + DW));
    assign out_of_range = (32'(addr_q) >= LIMIT);

    always_comb begin
        illegal = 1'b0;
        if (we_q) illegal = !(funct3_q inside {3'b000, 3'b001, 3'b010});
        else      illegal = !(funct3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                      ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
    // Misaligned halves/words are aligned by ignoring the low address bits in lane selection.
    assign misalign = 1'b0;
`endif

    assign fault  = out_of_range | illegal | misalign;
    assign acc_go = (state == S_ACC) && !stall && !fault;

    always_comb begin
        wstrb  = 4'b0000;
        wlanes = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                wstrb  = 4'b0001 << addr_q[1:0];
                wlanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wstrb  = addr_q[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata_q[15:0]}};
            end
            2'b10:   wstrb = 4'b1111;
            default: wstrb = 4'b0000;
        endcase
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [31:0] mem [DEPTH];
        logic [31:0] rd_q;

        assign bank_en[b] = acc_go && (bank_idx == BW'(b));

        always_ff @(posedge clk) begin
            if (bank_en[b]) begin
                if (we_q) begin
                    for (int i = 0; i < 4; i++) begin
                        if (wstrb[i]) mem[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
                    end
                end else begin
                    rd_q <= mem[word_idx];
                end
            end
        end

        assign bank_rd[b] = rd_q;
    end

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [7:0]  b8;
        logic [15:0] h16;
        b8  = 8'(w >> {off, 3'b000});
        h16 = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b8[7]}}, b8};
            3'b100:  return {24'd0, b8};
            3'b001:  return {{16{h16[15]}}, h16};
            3'b101:  return {16'd0, h16};
            default: return w;
        endcase
    endfunction

    // Bank read registers only change on an enabled load, so the response stays stable in RSP.
    assign rsp_rdata = load_ok_q ? load_ext(bank_rd[bank_idx], funct3_q, addr_q[1:0]) : 32'd0;
    assign req_ready = (state == S_IDLE) && !stall && nrst;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            funct3_q  <= 3'd0;
            we_q      <= 1'b0;
            wdata_q   <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            load_ok_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q   <= req_addr;
                        funct3_q <= req_funct3;
                        we_q     <= req_we;
                        wdata_q  <= req_wdata;
                        state    <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (!stall) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= fault;
                        load_ok_q <= !we_q && !fault;
                        state     <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready && !stall) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        load_ok_q <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bank_ctrl.sv
// Self-checking bench for dmem_bank_ctrl: byte-array reference model, directed cases, then random traffic.
// Honours DMEM_MISALIGN_TRAP_EN the same way as the design.
module tb_dmem_bank_ctrl;
    localparam int NB  = 2;
    localparam int DP  = 256;
    localparam int AW  = 14;
    localparam int LIM = NB * DP * 4;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          stall = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'd0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = 32'd0;
    logic          rsp_ready = 1'b0;
    logic          req_ready;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [1:0]    dbg_state;

    int checks = 0;
    int failures = 0;
    logic [7:0]  mref [LIM];
    logic [31:0] exp_q[$];
    logic        exp_err_q[$];

    dmem_bank_ctrl #(.NUM_BANKS(NB), .DEPTH(DP), .ADDR_W(AW)) dut (
        .clk(clk), .nrst(nrst), .stall(stall),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Byte-addressed memory image; loads/stores follow the ISA rules directly.
    task automatic model(input logic we, input logic [2:0] f3, input int unsigned addr,
                         input logic [31:0] wd, output logic err, output logic [31:0] rd);
        int unsigned size;
        int unsigned base;
        logic legal;
        size  = 1 << f3[1:0];
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err   = !legal || (addr >= LIM);
`ifdef DMEM_MISALIGN_TRAP_EN
        err   = err || ((addr % size) != 0);
`endif
        rd = 32'd0;
        if (!err) begin
            base = addr - (addr % size);
            if (we) begin
                for (int i = 0; i < int'(size); i++) mref[base + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < int'(size); i++) rd[8*i +: 8] = mref[base + i];
                if (!f3[2] && size < 4 && rd[8*size-1]) rd = rd | ~((32'd1 << (8*size)) - 32'd1);
            end
        end
    endtask

    // Called just after a negedge; returns just after a negedge with the response retired.
    task automatic do_op(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                         input logic [31:0] wd, input int holds,
                         output logic [31:0] rd, output logic er);
        logic        e_err;
        logic [31:0] e_rd;
        logic [31:0] first;
        int n;
        model(we, f3, 32'(addr), wd, e_err, e_rd);
        exp_q.push_back(e_rd);
        exp_err_q.push_back(e_err);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        check("accept_in_time", 32'(n < 20), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("acc_no_rsp", 32'(rsp_valid), 32'd0);
        check("acc_not_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("latency_rsp", 32'(rsp_valid), 32'd1);
        n = 0;
        while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
        first = rsp_rdata;
        er    = rsp_err;
        check("rdata", first, exp_q.pop_front());
        check("err", 32'(er), 32'(exp_err_q.pop_front()));
        for (int h = 0; h < holds; h++) begin
            stall     = 1'($urandom_range(0, 1));
            rsp_ready = stall ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, first);
        end
        stall = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("retired", 32'(rsp_valid), 32'd0);
        rd = first;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        e_err;
        logic [31:0] e_rd;
        logic [31:0] old;

        // Reset state
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // Give every word a known value
        for (int w = 0; w < LIM / 4; w++) do_op(1'b1, 3'b010, AW'(w * 4), $urandom, 0, rd, er);

        do_op(1'b1, 3'b010, 14'h0004, 32'hDEADBEEF, 0, rd, er);
        do_op(1'b0, 3'b010, 14'h0004, 32'd0, 0, rd, er);
        check("lw4_value", rd, 32'hDEADBEEF);
        do_op(1'b1, 3'b000, 14'h0007, 32'h00000080, 0, rd, er);
        do_op(1'b0, 3'b000, 14'h0007, 32'd0, 0, rd, er);
        check("lb7_value", rd, 32'hFFFFFF80);
        do_op(1'b0, 3'b100, 14'h0007, 32'd0, 0, rd, er);
        check("lbu7_value", rd, 32'h00000080);
        do_op(1'b0, 3'b010, 14'h0004, 32'd0, 0, rd, er);
        check("lw4_after_sb", rd, 32'h80ADBEEF);
        do_op(1'b1, 3'b001, 14'h040A, 32'h00001234, 0, rd, er);
        do_op(1'b0, 3'b010, 14'h0408, 32'd0, 0, rd, er);
        check("lw408_upper", {16'd0, rd[31:16]}, 32'h00001234);
        do_op(1'b0, 3'b010, 14'h0008, 32'd0, 0, rd, er);
        do_op(1'b0, 3'b001, 14'h040A, 32'd0, 0, rd, er);
        do_op(1'b0, 3'b101, 14'h0406, 32'd0, 0, rd, er);
        // Misaligned in-range word/half: model decides per build
        do_op(1'b0, 3'b010, 14'h0402, 32'd0, 0, rd, er);
        do_op(1'b0, 3'b001, 14'h0005, 32'd0, 0, rd, er);
        do_op(1'b1, 3'b001, 14'h0013, 32'h0000A5C3, 0, rd, er);
        do_op(1'b0, 3'b010, 14'h0010, 32'd0, 0, rd, er);
        // 0x0802 is past the last byte of two 1 KiB banks
        do_op(1'b0, 3'b010, 14'h0802, 32'd0, 0, rd, er);
        check("lw802_err", 32'(er), 32'd1);
        do_op(1'b0, 3'b010, 14'h3000, 32'd0, 0, rd, er);
        check("lw3000_err", 32'(er), 32'd1);
        do_op(1'b0, 3'b010, 14'h07FC, 32'd0, 0, rd, er);
        check("lw7fc_ok", 32'(er), 32'd0);
        do_op(1'b1, 3'b011, 14'h0020, 32'h12345678, 0, rd, er);
        check("illegal_st_err", 32'(er), 32'd1);
        do_op(1'b0, 3'b010, 14'h0020, 32'd0, 0, rd, er);
        do_op(1'b0, 3'b110, 14'h0020, 32'd0, 0, rd, er);
        check("illegal_ld_rdata", rd, 32'd0);

        // Stall blocks accept, freezes ACC and holds RSP
        stall = 1'b1;
        #1 check("stall_idle_ready", 32'(req_ready), 32'd0);
        stall = 1'b0;
        model(1'b0, 3'b010, 32'h4, 32'd0, e_err, e_rd);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 14'h0004;
        #1 check("stall_test_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        stall = 1'b1;
        @(negedge clk);
        check("acc_stall_1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("acc_stall_2", 32'(rsp_valid), 32'd0);
        stall = 1'b0;
        @(negedge clk);
        check("acc_resume_valid", 32'(rsp_valid), 32'd1);
        check("acc_resume_rdata", rsp_rdata, e_rd);
        stall = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rsp_stall_valid", 32'(rsp_valid), 32'd1);
            check("rsp_stall_rdata", rsp_rdata, e_rd);
        end
        stall = 1'b0;
        @(negedge clk);
        check("rsp_stall_retire", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;

        // Reset during ACC of a store: the store must not land
        old = {mref[19], mref[18], mref[17], mref[16]};
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 14'h0010; req_wdata = ~old;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_acc", 32'(dbg_state), 32'd1);
        nrst = 1'b0;
        #1;
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        #1 check("midrst_release_ready", 32'(req_ready), 32'd1);
        do_op(1'b0, 3'b010, 14'h0010, 32'd0, 0, rd, er);
        check("midrst_old_value", rd, old);

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            logic          we;
            logic [2:0]    f3;
            logic [AW-1:0] a;
            we = ($urandom_range(0, 2) == 0);
            f3 = (we && $urandom_range(0, 7) != 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 9) != 0) ? AW'($urandom_range(0, LIM - 1))
                                             : AW'($urandom_range(0, (1 << AW) - 1));
            do_op(we, f3, a, $urandom, $urandom_range(0, 2), rd, er);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
